// File: rtl/wb_stage.sv
// wb_stage: writeback stage that sits directly after the memory stage.
//
// Purpose:
//   - Registers one instruction's results from the memory stage and drives
//     the register-file write port one cycle after the instruction is accepted.
//   - For loads, picks the addressed bytes out of the aligned doubleword and
//     sign- or zero-extends them.
//   - For "ecall", raises a syscall request and waits for the completion
//     pulse. It then writes the return value to a0 and pulses a one-cycle
//     flush to the upstream stages.
//
// Ports:
//   clk                clock, rising edge
//   reset              asynchronous, active-low reset
//   in_enable          memory stage presents a valid instruction
//   in_alu_result      ALU result; effective address for loads
//   in_mdata           aligned doubleword read for loads
//   in_rd_regno        destination register
//   in_update_rd_bool  instruction writes rd
//   in_mm_load_bool    instruction is a load
//   in_opcode_name     right-justified ASCII opcode name
//   out_ready          stage can accept (combinational from state)
//   out_wr_en          register-file write enable (registered)
//   out_wr_regno       register-file write index (registered)
//   out_wr_data        register-file write data (registered)
//   out_ecall_req      syscall request level (registered)
//   in_ecall_done      syscall complete, one-cycle pulse
//   in_ecall_ret       syscall return value, valid with in_ecall_done
//   out_syscall_flush  one-cycle flush pulse to upstream stages (registered)
//
// States:
//   state      | meaning
//   -----------+--------------------------------------------------------
//   IDLE       | accepting instructions, normal writeback
//   ECALL_WAIT | syscall requested, waiting for in_ecall_done
//   FLUSH      | a0 write and flush pulse are on the outputs; back to IDLE

module wb_stage #(
  parameter int REGISTER_WIDTH         = 64,
  parameter int REGISTERNO_WIDTH       = 5,
  parameter int INSTRUCTION_NAME_WIDTH = 96,
  parameter int ECALL_RET_REGNO        = 10
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_enable,
  input  logic [REGISTER_WIDTH-1:0]         in_alu_result,
  input  logic [REGISTER_WIDTH-1:0]         in_mdata,
  input  logic [REGISTERNO_WIDTH-1:0]       in_rd_regno,
  input  logic                              in_update_rd_bool,
  input  logic                              in_mm_load_bool,
  input  logic [INSTRUCTION_NAME_WIDTH-1:0] in_opcode_name,
  output logic                              out_ready,
  output logic                              out_wr_en,
  output logic [REGISTERNO_WIDTH-1:0]       out_wr_regno,
  output logic [REGISTER_WIDTH-1:0]         out_wr_data,
  output logic                              out_ecall_req,
  input  logic                              in_ecall_done,
  input  logic [REGISTER_WIDTH-1:0]         in_ecall_ret,
  output logic                              out_syscall_flush
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ECALL_WAIT = 2'd1,
    FLUSH      = 2'd2
  } state_t;

  // Opcode names are right-justified ASCII, so the size cast zero-fills the
  // upper characters the same way the decoder upstream does.
  localparam logic [INSTRUCTION_NAME_WIDTH-1:0] OP_ECALL = INSTRUCTION_NAME_WIDTH'("ecall");
  localparam logic [INSTRUCTION_NAME_WIDTH-1:0] OP_LB    = INSTRUCTION_NAME_WIDTH'("lb");
  localparam logic [INSTRUCTION_NAME_WIDTH-1:0] OP_LBU   = INSTRUCTION_NAME_WIDTH'("lbu");
  localparam logic [INSTRUCTION_NAME_WIDTH-1:0] OP_LH    = INSTRUCTION_NAME_WIDTH'("lh");
  localparam logic [INSTRUCTION_NAME_WIDTH-1:0] OP_LHU   = INSTRUCTION_NAME_WIDTH'("lhu");
  localparam logic [INSTRUCTION_NAME_WIDTH-1:0] OP_LW    = INSTRUCTION_NAME_WIDTH'("lw");
  localparam logic [INSTRUCTION_NAME_WIDTH-1:0] OP_LWU   = INSTRUCTION_NAME_WIDTH'("lwu");

  localparam logic [REGISTERNO_WIDTH-1:0] RET_REGNO = REGISTERNO_WIDTH'(ECALL_RET_REGNO);

  state_t                        state;
  logic                          accept;
  logic                          is_ecall;
  logic                          rd_nonzero;
  logic [2:0]                    off;
  logic [REGISTER_WIDTH-1:0]     sh;
  logic [REGISTER_WIDTH-1:0]     load_data;
  logic [REGISTER_WIDTH-1:0]     wb_data;

  assign out_ready  = (state == IDLE);
  assign accept     = in_enable && out_ready;
  assign is_ecall   = (in_opcode_name == OP_ECALL);
  assign rd_nonzero = (in_rd_regno != '0);

  // Byte offset within the doubleword selects the lane. A misaligned half or
  // word is not split across doublewords, so it picks up zeros from the top.
  assign off = in_alu_result[2:0];
  assign sh  = in_mdata >> {off, 3'b000};

  always_comb begin
    load_data = sh;
    if (in_opcode_name == OP_LB) begin
      load_data = {{(REGISTER_WIDTH-8){sh[7]}}, sh[7:0]};
    end else if (in_opcode_name == OP_LBU) begin
      load_data = {{(REGISTER_WIDTH-8){1'b0}}, sh[7:0]};
    end else if (in_opcode_name == OP_LH) begin
      load_data = {{(REGISTER_WIDTH-16){sh[15]}}, sh[15:0]};
    end else if (in_opcode_name == OP_LHU) begin
      load_data = {{(REGISTER_WIDTH-16){1'b0}}, sh[15:0]};
    end else if (in_opcode_name == OP_LW) begin
      load_data = {{(REGISTER_WIDTH-32){sh[31]}}, sh[31:0]};
    end else if (in_opcode_name == OP_LWU) begin
      load_data = {{(REGISTER_WIDTH-32){1'b0}}, sh[31:0]};
    end
    // "ld" and any unrecognised load opcode take the shifted doubleword as is.
  end

  assign wb_data = in_mm_load_bool ? load_data : in_alu_result;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      out_wr_en         <= 1'b0;
      out_wr_regno      <= '0;
      out_wr_data       <= '0;
      out_ecall_req     <= 1'b0;
      out_syscall_flush <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          out_syscall_flush <= 1'b0;
          out_wr_en         <= 1'b0;
          if (accept) begin
            if (is_ecall) begin
              // in_ecall_done is not looked at here: the request has to be
              // visible before a completion can count.
              out_ecall_req <= 1'b1;
              state         <= ECALL_WAIT;
            end else begin
              out_wr_en    <= in_update_rd_bool && rd_nonzero;
              out_wr_regno <= in_rd_regno;
              out_wr_data  <= wb_data;
            end
          end
        end
        ECALL_WAIT: begin
          out_wr_en <= 1'b0;
          if (in_ecall_done) begin
            out_ecall_req     <= 1'b0;
            out_wr_en         <= 1'b1;
            out_wr_regno      <= RET_REGNO;
            out_wr_data       <= in_ecall_ret;
            out_syscall_flush <= 1'b1;
            state             <= FLUSH;
          end
        end
        FLUSH: begin
          out_wr_en         <= 1'b0;
          out_syscall_flush <= 1'b0;
          state             <= IDLE;
        end
        default: begin
          out_wr_en         <= 1'b0;
          out_ecall_req     <= 1'b0;
          out_syscall_flush <= 1'b0;
          state             <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  logic        clk;
  logic        reset;
  logic        in_enable;
  logic [63:0] in_alu_result;
  logic [63:0] in_mdata;
  logic [4:0]  in_rd_regno;
  logic        in_update_rd_bool;
  logic        in_mm_load_bool;
  logic [95:0] in_opcode_name;
  logic        out_ready;
  logic        out_wr_en;
  logic [4:0]  out_wr_regno;
  logic [63:0] out_wr_data;
  logic        out_ecall_req;
  logic        in_ecall_done;
  logic [63:0] in_ecall_ret;
  logic        out_syscall_flush;

  typedef struct {
    logic [4:0]  regno;
    logic [63:0] data;
    logic        flush;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  wb_stage dut (
    .clk               (clk),
    .reset             (reset),
    .in_enable         (in_enable),
    .in_alu_result     (in_alu_result),
    .in_mdata          (in_mdata),
    .in_rd_regno       (in_rd_regno),
    .in_update_rd_bool (in_update_rd_bool),
    .in_mm_load_bool   (in_mm_load_bool),
    .in_opcode_name    (in_opcode_name),
    .out_ready         (out_ready),
    .out_wr_en         (out_wr_en),
    .out_wr_regno      (out_wr_regno),
    .out_wr_data       (out_wr_data),
    .out_ecall_req     (out_ecall_req),
    .in_ecall_done     (in_ecall_done),
    .in_ecall_ret      (in_ecall_ret),
    .out_syscall_flush (out_syscall_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every register-file write must match the oldest expected write.
  always @(negedge clk) begin
    if (reset) begin
      if (out_wr_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got regno=%0d data=0x%0h expected no write",
                   out_wr_regno, out_wr_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (out_wr_regno !== e.regno || out_wr_data !== e.data || out_syscall_flush !== e.flush) begin
            errors++;
            $display("FAIL write: got regno=%0d data=0x%0h flush=%0b expected regno=%0d data=0x%0h flush=%0b",
                     out_wr_regno, out_wr_data, out_syscall_flush, e.regno, e.data, e.flush);
          end
        end
      end else if (out_syscall_flush) begin
        checks++;
        errors++;
        $display("FAIL flush_without_write: got flush=1 expected 0");
      end
    end
  end

  task automatic expect_write(input logic [4:0] regno, input logic [63:0] data, input logic flush);
    exp_t e;
    e.regno = regno;
    e.data  = data;
    e.flush = flush;
    exp_q.push_back(e);
  endtask

  // Presents one instruction for one clock edge (caller is at a negedge).
  task automatic issue(input logic [95:0] name, input logic [63:0] alu, input logic [63:0] mdata,
                       input logic [4:0] rd, input logic upd, input logic ld,
                       input logic exp_wr, input logic [63:0] exp_data);
    in_opcode_name    = name;
    in_alu_result     = alu;
    in_mdata          = mdata;
    in_rd_regno       = rd;
    in_update_rd_bool = upd;
    in_mm_load_bool   = ld;
    in_enable         = 1'b1;
    if (exp_wr) expect_write(rd, exp_data, 1'b0);
    @(negedge clk);
    in_enable = 1'b0;
  endtask

  initial begin
    reset             = 1'b0;
    in_enable         = 1'b0;
    in_alu_result     = '0;
    in_mdata          = '0;
    in_rd_regno       = '0;
    in_update_rd_bool = 1'b0;
    in_mm_load_bool   = 1'b0;
    in_opcode_name    = '0;
    in_ecall_done     = 1'b0;
    in_ecall_ret      = '0;

    // 1. reset state
    repeat (2) @(negedge clk);
    check("rst_wr_en",  {63'd0, out_wr_en},         64'd0);
    check("rst_regno",  {59'd0, out_wr_regno},      64'd0);
    check("rst_data",   out_wr_data,                64'd0);
    check("rst_ecall",  {63'd0, out_ecall_req},     64'd0);
    check("rst_flush",  {63'd0, out_syscall_flush}, 64'd0);
    check("rst_ready",  {63'd0, out_ready},         64'd1);
    reset = 1'b1;
    @(negedge clk);

    issue(96'("add"), 64'h1234, 64'h0, 5'd5, 1'b1, 1'b0, 1'b1, 64'h1234);
    @(negedge clk);
    check("idle_wr_en",  {63'd0, out_wr_en},    64'd0);
    check("idle_regno",  {59'd0, out_wr_regno}, 64'd5);
    check("idle_data",   out_wr_data,           64'h1234);

    // 2/3. load extraction, back to back
    issue(96'("lb"),  64'h1003, 64'h0000_0000_8000_0000, 5'd7, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FF80);
    issue(96'("lbu"), 64'h1003, 64'h0000_0000_8000_0000, 5'd7, 1'b1, 1'b1, 1'b1, 64'h80);
    issue(96'("lhu"), 64'h2006, 64'hBEEF_0000_0000_0000, 5'd8, 1'b1, 1'b1, 1'b1, 64'hBEEF);
    issue(96'("lh"),  64'h2006, 64'hBEEF_0000_0000_0000, 5'd8, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_BEEF);
    issue(96'("lw"),  64'h2004, 64'h8765_4321_0000_0000, 5'd9, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_8765_4321);
    issue(96'("lwu"), 64'h2004, 64'h8765_4321_0000_0000, 5'd9, 1'b1, 1'b1, 1'b1, 64'h8765_4321);
    // misaligned word: upper bytes come in as zero, so bit 31 is 0
    issue(96'("lw"),  64'h2006, 64'hBEEF_0000_0000_0000, 5'd11, 1'b1, 1'b1, 1'b1, 64'hBEEF);
    issue(96'("ld"),  64'h3000, 64'hDEAD_BEEF_CAFE_F00D, 5'd12, 1'b1, 1'b1, 1'b1, 64'hDEAD_BEEF_CAFE_F00D);
    issue(96'("foo"), 64'h3000, 64'h0123_4567_89AB_CDEF, 5'd13, 1'b1, 1'b1, 1'b1, 64'h0123_4567_89AB_CDEF);

    // 4. no-write cases
    issue(96'("addi"), 64'h55, 64'h0, 5'd0, 1'b1, 1'b0, 1'b0, 64'h0);
    issue(96'("sd"),   64'h66, 64'h0, 5'd3, 1'b0, 1'b0, 1'b0, 64'h0);
    check("nowrite_en", {63'd0, out_wr_en}, 64'd0);

    // in_ecall_done while idle is ignored (monitor flags any write)
    in_ecall_done = 1'b1;
    in_ecall_ret  = 64'h77;
    @(negedge clk);
    in_ecall_done = 1'b0;

    // 5. ecall; a done pulse on the entering edge must not count
    in_ecall_done = 1'b1;
    issue(96'("ecall"), 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 64'h0);
    in_ecall_done = 1'b0;
    check("ecall_req",   {63'd0, out_ecall_req}, 64'd1);
    check("ecall_ready", {63'd0, out_ready},     64'd0);
    in_opcode_name    = 96'("add");
    in_rd_regno       = 5'd3;
    in_alu_result     = 64'h99;
    in_update_rd_bool = 1'b1;
    in_mm_load_bool   = 1'b0;
    in_enable         = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("wait_ready", {63'd0, out_ready},     64'd0);
      check("wait_req",   {63'd0, out_ecall_req}, 64'd1);
    end
    in_enable     = 1'b0;
    in_ecall_done = 1'b1;
    in_ecall_ret  = 64'h2A;
    expect_write(5'd10, 64'h2A, 1'b1);
    @(negedge clk);
    in_ecall_done = 1'b0;
    check("done_flush", {63'd0, out_syscall_flush}, 64'd1);
    check("done_req",   {63'd0, out_ecall_req},     64'd0);
    @(negedge clk);
    check("post_flush", {63'd0, out_syscall_flush}, 64'd0);
    check("post_ready", {63'd0, out_ready},         64'd1);

    // 6. reset mid-ECALL_WAIT aborts the sequence
    issue(96'("ecall"), 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 64'h0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_req",   {63'd0, out_ecall_req},     64'd0);
    check("arst_wr_en", {63'd0, out_wr_en},         64'd0);
    check("arst_flush", {63'd0, out_syscall_flush}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    in_ecall_done = 1'b1;
    in_ecall_ret  = 64'h5;
    @(negedge clk);
    in_ecall_done = 1'b0;
    check("arst_ready", {63'd0, out_ready},     64'd1);
    check("arst_req2",  {63'd0, out_ecall_req}, 64'd0);

    // stage still works after the abort
    issue(96'("add"), 64'hABC, 64'h0, 5'd4, 1'b1, 1'b0, 1'b1, 64'hABC);
    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
